// File: rtl/tl_ul_pkg.sv
// Shared TL-UL definitions: opcode constants and the fixed-width channel payloads.
package tl_ul_pkg;

  localparam logic [2:0] OP_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] OP_GET              = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK       = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA  = 3'd1;

  // Source is appended by the user because its width is chosen per instance.
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [1:0]  size;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [1:0]  size;
    logic        sink;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } tl_d_t;

  function automatic logic is_access_ack(input logic [2:0] op);
    return (op == OP_ACCESS_ACK) || (op == OP_ACCESS_ACK_DATA);
  endfunction

endpackage

// File: rtl/tl_ul_fifo.sv
// DEPTH-entry register FIFO; callers qualify push/pop with their own full/empty view.
module tl_ul_fifo
  import tl_ul_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 wr_data_i,
  output logic [W-1:0]                 rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
    if (push_i) wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/tl_ul_channel_buffer.sv
// Registered TL-UL A/D channel buffer with outstanding-request limiting on A.
module tl_ul_channel_buffer
  import tl_ul_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned SRC_W        = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_a_valid,
  output logic             in_a_ready,
  input  logic [2:0]       in_a_opcode,
  input  logic [2:0]       in_a_param,
  input  logic [1:0]       in_a_size,
  input  logic [SRC_W-1:0] in_a_source,
  input  logic [31:0]      in_a_address,
  input  logic [3:0]       in_a_mask,
  input  logic [31:0]      in_a_data,
  input  logic             in_a_corrupt,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [2:0]       out_a_opcode,
  output logic [2:0]       out_a_param,
  output logic [1:0]       out_a_size,
  output logic [SRC_W-1:0] out_a_source,
  output logic [31:0]      out_a_address,
  output logic [3:0]       out_a_mask,
  output logic [31:0]      out_a_data,
  output logic             out_a_corrupt,
  input  logic             out_d_valid,
  output logic             out_d_ready,
  input  logic [2:0]       out_d_opcode,
  input  logic [1:0]       out_d_param,
  input  logic [1:0]       out_d_size,
  input  logic [SRC_W-1:0] out_d_source,
  input  logic             out_d_sink,
  input  logic             out_d_denied,
  input  logic [31:0]      out_d_data,
  input  logic             out_d_corrupt,
  output logic             in_d_valid,
  input  logic             in_d_ready,
  output logic [2:0]       in_d_opcode,
  output logic [1:0]       in_d_param,
  output logic [1:0]       in_d_size,
  output logic [SRC_W-1:0] in_d_source,
  output logic             in_d_sink,
  output logic             in_d_denied,
  output logic [31:0]      in_d_data,
  output logic             in_d_corrupt,
  output logic [3:0]       inflight
);

  localparam int unsigned CW  = $clog2(DEPTH+1);
  localparam int unsigned A_W = $bits(tl_a_t) + SRC_W;
  localparam int unsigned D_W = $bits(tl_d_t) + SRC_W;

  tl_a_t          a_wr, a_rd;
  tl_d_t          d_wr, d_rd;
  logic [A_W-1:0] a_rd_data;
  logic [D_W-1:0] d_rd_data;
  logic [CW-1:0]  a_count, d_count;
  logic           a_push, a_pop, d_push, d_pop, ack_pop;
  logic           rdy_en_q;
  logic [3:0]     inflight_q, inflight_d;
  logic           err_underflow, err_underflow_d;

  assign a_wr = '{opcode: in_a_opcode, param: in_a_param, size: in_a_size,
                  address: in_a_address, mask: in_a_mask, data: in_a_data,
                  corrupt: in_a_corrupt};
  assign d_wr = '{opcode: out_d_opcode, param: out_d_param, size: out_d_size,
                  sink: out_d_sink, denied: out_d_denied, data: out_d_data,
                  corrupt: out_d_corrupt};

  // Readies stay low in reset and for the edge that releases it.
  assign in_a_ready  = rdy_en_q && (a_count != CW'(DEPTH)) &&
                       (({1'b0, inflight_q} + 5'(a_count)) < 5'(MAX_INFLIGHT));
  assign out_d_ready = rdy_en_q && (d_count != CW'(DEPTH));
  assign out_a_valid = (a_count != '0);
  assign in_d_valid  = (d_count != '0);

  assign a_push  = in_a_valid && in_a_ready;
  assign a_pop   = out_a_valid && out_a_ready;
  assign d_push  = out_d_valid && out_d_ready;
  assign d_pop   = in_d_valid && in_d_ready;
  assign ack_pop = d_pop && is_access_ack(d_rd.opcode);

  tl_ul_fifo #(.W(A_W), .DEPTH(DEPTH)) u_a_fifo (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .push_i    (a_push),
    .pop_i     (a_pop),
    .wr_data_i ({in_a_source, a_wr}),
    .rd_data_o (a_rd_data),
    .count_o   (a_count)
  );

  tl_ul_fifo #(.W(D_W), .DEPTH(DEPTH)) u_d_fifo (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .push_i    (d_push),
    .pop_i     (d_pop),
    .wr_data_i ({out_d_source, d_wr}),
    .rd_data_o (d_rd_data),
    .count_o   (d_count)
  );

  assign {out_a_source, a_rd} = a_rd_data;
  assign {in_d_source, d_rd}  = d_rd_data;

  assign out_a_opcode  = a_rd.opcode;
  assign out_a_param   = a_rd.param;
  assign out_a_size    = a_rd.size;
  assign out_a_address = a_rd.address;
  assign out_a_mask    = a_rd.mask;
  assign out_a_data    = a_rd.data;
  assign out_a_corrupt = a_rd.corrupt;

  assign in_d_opcode  = d_rd.opcode;
  assign in_d_param   = d_rd.param;
  assign in_d_size    = d_rd.size;
  assign in_d_sink    = d_rd.sink;
  assign in_d_denied  = d_rd.denied;
  assign in_d_data    = d_rd.data;
  assign in_d_corrupt = d_rd.corrupt;

  always_comb begin
    inflight_d      = inflight_q;
    err_underflow_d = err_underflow;
    if (a_pop && !ack_pop) begin
      if (inflight_q < 4'(MAX_INFLIGHT)) inflight_d = inflight_q + 4'd1;
    end else if (ack_pop && !a_pop) begin
      if (inflight_q == '0) err_underflow_d = 1'b1;
      else                  inflight_d      = inflight_q - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en_q      <= 1'b0;
      inflight_q    <= '0;
      err_underflow <= 1'b0;
    end else begin
      rdy_en_q      <= 1'b1;
      inflight_q    <= inflight_d;
      err_underflow <= err_underflow_d;
    end
  end

  assign inflight = inflight_q;

endmodule
